tube_field_engine: RTL and testbench
====================================

// Module: tube_field_engine
// PURPOSE
//  Parametrised successor of the fixed three-tube mover. Scrolls NUM_TUBES obstacles leftwards, one step per frame strobe.
//  Regenerates each tube's gap height from a free-running LFSR when the tube wraps.
//  Counts passed tubes as score and raises scroll speed by level. Feeds bitgen/collision via flat position buses.
// PARAMETERS
//  NUM_TUBES   3       number of tubes; tube i occupies bus slice [i*POS_W +: POS_W]
//  POS_W       10      coordinate width (pixels)
//  START_X     400     reset x of tube 0; tube i resets to START_X + i*SPACING
//  SPACING     200     horizontal pitch; NUM_TUBES*SPACING and START_X+(NUM_TUBES-1)*SPACING < 2**POS_W
//  TUBE_W      40      tube width in pixels (x = left edge)
//  BIRD_X      160     bird x column used for pass detection
//  GAP_MIN     80      minimum gap y; reset y of tube i = GAP_MIN + 32*i
//  RAND_BITS   8       new gap y = GAP_MIN + lfsr[RAND_BITS-1:0]
//  BASE_SPEED  2       pixels per frame at level 0; step = BASE_SPEED + level
//  LEVEL_EVERY 5       score points per level increase
//  MAX_LEVEL   3       level saturation value
//  SCORE_W     8       score width
//  LFSR_SEED   16'hACE1 nonzero LFSR reset value
// PORTS
//  clk          in   1                    system clock
//  clr          in   1                    reset, asynchronous, active-high
//  frame_tick   in   1                    one-clk strobe per frame, synchronous to clk
//  game_end     in   1                    freeze request from collision detect
//  tube_x       out  NUM_TUBES*POS_W      packed tube left-edge x
//  tube_y       out  NUM_TUBES*POS_W      packed tube gap y
//  score        out  SCORE_W              tubes passed, saturating
//  level        out  clog2(MAX_LEVEL+1)   current speed level
//  tube_passed  out  1                    one-clk pulse when score increments
// BEHAVIOUR
//  - One clock (clk); clr asynchronous, active-high. All outputs registered.
//  - Reset values: tube_x[i]=START_X+i*SPACING, tube_y[i]=GAP_MIN+32*i, score=0, level=0, tube_passed=0, lfsr=LFSR_SEED.
//  - LFSR: 16-bit Galois, taps mask 16'hB400, shift right. It advances every clk, including during game_end and idle cycles.
//  - Update occurs only on a clk edge with frame_tick=1 and game_end=0. All tubes update in that same edge. Results are visible on the next cycle (latency 1).
//  - Per tube, with s = BASE_SPEED+level:
//      x >= s  -> x_next = x - s, y unchanged
//      x <  s  -> wrap: x_next = x + NUM_TUBES*SPACING - s, and y_next = GAP_MIN + lfsr[RAND_BITS-1:0], sampled that edge
//  - Pass: a non-wrapping tube with x+TUBE_W > BIRD_X and x_next+TUBE_W <= BIRD_X counts as passed. Compare in POS_W+1 bits.
//  - Score adds the count of tubes passed this frame and saturates at 2**SCORE_W-1.
//  - tube_passed=1 for exactly one cycle if the count is >0. No pulse once score is saturated.
//  - Level = min(MAX_LEVEL, score/LEVEL_EVERY). Implement as a counter of points since the last level-up; no divider.
//    The new level takes effect from the next frame.
//  - game_end=1: x, y, score and level hold; tube_passed=0; frame_tick is ignored. Motion resumes on the first frame_tick after game_end falls.
//  - frame_tick is ignored while clr is high. clr mid-frame returns everything to reset values immediately.
//  - Simultaneous wrap and pass on the same tube: no score for that tube.
// TESTING
//  1. Assert clr, release -> tube_x={400,600,800}, tube_y={80,112,144}, score=0, level=0.
//  2. Single frame_tick -> next cycle tube_x={398,598,798}; y unchanged; tube_passed=0.
//  3. game_end=1, 10 frame_ticks -> nothing changes. game_end=0, 1 tick -> all x decrease by 2.
//  4. 140 ticks from reset -> tube0 x=120; score=1; tube_passed high exactly one cycle.
//  5. Force tube0 x=1 at level 0, tick -> x=599, y in [80,335] equal to 80+lfsr[7:0]; score unchanged.
//  6. Drive score to 5 -> level=1, step=3 from the following frame. Score 15+ -> level stays 3. Score holds at 255.

Source files
------------

// File: rtl/tube_field_engine.sv
// tube_field_engine: scrolls NUM_TUBES obstacles leftwards by one step per
// frame strobe, regenerates gap heights from a free-running LFSR on wrap,
// counts tubes passed by the bird and raises scroll speed with the score.
//
// Ports
//   clk          system clock
//   clr          asynchronous active-high reset
//   frame_tick   one-clk frame strobe, synchronous to clk
//   game_end     freeze request (holds position, score and level)
//   tube_x       packed tube left-edge x, tube i at [i*POS_W +: POS_W]
//   tube_y       packed tube gap y, same packing as tube_x
//   score        tubes passed, saturating
//   level        current speed level, saturating at MAX_LEVEL
//   tube_passed  one-clk pulse when the score increments
module tube_field_engine #(
  parameter int unsigned  NUM_TUBES   = 3,
  parameter int unsigned  POS_W       = 10,
  parameter int unsigned  START_X     = 400,
  parameter int unsigned  SPACING     = 200,
  parameter int unsigned  TUBE_W      = 40,
  parameter int unsigned  BIRD_X      = 160,
  parameter int unsigned  GAP_MIN     = 80,
  parameter int unsigned  RAND_BITS   = 8,
  parameter int unsigned  BASE_SPEED  = 2,
  parameter int unsigned  LEVEL_EVERY = 5,
  parameter int unsigned  MAX_LEVEL   = 3,
  parameter int unsigned  SCORE_W     = 8,
  parameter logic [15:0]  LFSR_SEED   = 16'hACE1,
  localparam int unsigned LVL_W       = $clog2(MAX_LEVEL + 1)
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         frame_tick,
  input  logic                         game_end,
  output logic [NUM_TUBES*POS_W-1:0]   tube_x,
  output logic [NUM_TUBES*POS_W-1:0]   tube_y,
  output logic [SCORE_W-1:0]           score,
  output logic [LVL_W-1:0]             level,
  output logic                         tube_passed
);

  localparam int unsigned XW    = POS_W + 1;
  localparam int unsigned CNT_W = $clog2(NUM_TUBES + 1);
  localparam int unsigned PTS_W = $clog2(LEVEL_EVERY + NUM_TUBES + 1);
  localparam logic [XW-1:0]      RING      = XW'(NUM_TUBES * SPACING);
  localparam logic [XW-1:0]      TUBE_WX   = XW'(TUBE_W);
  localparam logic [XW-1:0]      BIRD_XX   = XW'(BIRD_X);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [15:0]        LFSR_TAPS = 16'hB400;

  logic [15:0]                 lfsr;
  logic [15:0]                 lfsr_nxt;
  logic [PTS_W-1:0]            pts;
  logic [PTS_W-1:0]            pts_sum;
  logic [PTS_W-1:0]            pts_nxt;
  logic [LVL_W-1:0]            level_nxt;
  logic [XW-1:0]               step;
  logic [XW-1:0]               x_cur;
  logic [XW-1:0]               x_new;
  logic [NUM_TUBES*POS_W-1:0]  x_nxt;
  logic [NUM_TUBES*POS_W-1:0]  y_nxt;
  logic [CNT_W-1:0]            pass_cnt;
  logic [SCORE_W:0]            score_sum;
  logic [SCORE_W-1:0]          score_nxt;
  logic [SCORE_W-1:0]          gained;

  // Galois LFSR, shift right; free-running regardless of game state
  always_comb begin
    lfsr_nxt = {1'b0, lfsr[15:1]};
    if (lfsr[0]) lfsr_nxt = lfsr_nxt ^ LFSR_TAPS;
  end

  assign step = XW'(BASE_SPEED) + XW'(level);

  // Per-tube move/wrap and pass detection; a wrapping tube never scores
  always_comb begin
    x_nxt    = tube_x;
    y_nxt    = tube_y;
    pass_cnt = '0;
    x_cur    = '0;
    x_new    = '0;
    for (int i = 0; i < NUM_TUBES; i++) begin
      x_cur = {1'b0, tube_x[i*POS_W +: POS_W]};
      if (x_cur < step) begin
        x_new = x_cur + RING - step;
        y_nxt[i*POS_W +: POS_W] = POS_W'(GAP_MIN) + POS_W'(lfsr[RAND_BITS-1:0]);
      end else begin
        x_new = x_cur - step;
        if ((x_cur + TUBE_WX > BIRD_XX) && (x_new + TUBE_WX <= BIRD_XX))
          pass_cnt = pass_cnt + CNT_W'(1);
      end
      x_nxt[i*POS_W +: POS_W] = x_new[POS_W-1:0];
    end
  end

  // Saturating score; 'gained' is the increment actually applied
  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W+1)'(pass_cnt);
    score_nxt = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[SCORE_W-1:0];
    gained    = score_nxt - score;
  end

  // Level counter: points since the last level-up replace a divider
  always_comb begin
    pts_sum   = pts + PTS_W'(gained);
    pts_nxt   = pts;
    level_nxt = level;
    if (level < LVL_W'(MAX_LEVEL)) begin
      if (pts_sum >= PTS_W'(LEVEL_EVERY)) begin
        pts_nxt   = pts_sum - PTS_W'(LEVEL_EVERY);
        level_nxt = level + LVL_W'(1);
      end else begin
        pts_nxt = pts_sum;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      lfsr        <= LFSR_SEED;
      score       <= '0;
      level       <= '0;
      pts         <= '0;
      tube_passed <= 1'b0;
      for (int i = 0; i < NUM_TUBES; i++) begin
        tube_x[i*POS_W +: POS_W] <= POS_W'(START_X + i * SPACING);
        tube_y[i*POS_W +: POS_W] <= POS_W'(GAP_MIN + 32 * i);
      end
    end else begin
      lfsr        <= lfsr_nxt;
      tube_passed <= 1'b0;
      if (frame_tick && !game_end) begin
        tube_x      <= x_nxt;
        tube_y      <= y_nxt;
        score       <= score_nxt;
        level       <= level_nxt;
        pts         <= pts_nxt;
        tube_passed <= (gained != '0);
      end
    end
  end

endmodule

// File: tb/tb_tube_field_engine.sv
// tb_tube_field_engine: directed scenarios plus randomized frame/freeze/reset
// traffic, compared every cycle against a behavioural model of the tube field.
module tb_tube_field_engine;

  localparam int NT = 3;
  localparam int PW = 10;

  logic            clk;
  logic            clr;
  logic            frame_tick;
  logic            game_end;
  logic [NT*PW-1:0] tube_x;
  logic [NT*PW-1:0] tube_y;
  logic [7:0]      score;
  logic [1:0]      level;
  logic            tube_passed;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int          mx [NT];
  int          my [NT];
  int          mscore;
  int          mlevel;
  int          mpulse;
  logic [15:0] mlfsr;

  tube_field_engine dut (
    .clk         (clk),
    .clr         (clr),
    .frame_tick  (frame_tick),
    .game_end    (game_end),
    .tube_x      (tube_x),
    .tube_y      (tube_y),
    .score       (score),
    .level       (level),
    .tube_passed (tube_passed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int dut_x(input int i);
    return int'(tube_x[i*PW +: PW]);
  endfunction

  function automatic int dut_y(input int i);
    return int'(tube_y[i*PW +: PW]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      mx[i] = 400 + i * 200;
      my[i] = 80 + 32 * i;
    end
    mscore = 0;
    mlevel = 0;
    mpulse = 0;
    mlfsr  = 16'hACE1;
  endtask

  // One game frame from the rules: move or wrap, count passes, rescore
  task automatic model_frame();
    int s;
    int passed;
    int nx;
    int old;
    s      = 2 + mlevel;
    passed = 0;
    for (int i = 0; i < NT; i++) begin
      if (mx[i] >= s) begin
        nx = mx[i] - s;
        if (mx[i] + 40 > 160 && nx + 40 <= 160) passed++;
        mx[i] = nx;
      end else begin
        mx[i] = mx[i] + 600 - s;
        my[i] = 80 + int'(mlfsr & 16'h00FF);
      end
    end
    old    = mscore;
    mscore = (mscore + passed > 255) ? 255 : mscore + passed;
    mpulse = (mscore != old) ? 1 : 0;
    mlevel = (mscore / 5 > 3) ? 3 : mscore / 5;
  endtask

  always @(posedge clk) begin
    if (clr) begin
      model_reset();
    end else begin
      if (frame_tick && !game_end) model_frame();
      else mpulse = 0;
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 16'hB400) : (mlfsr >> 1);
    end
  end

  task automatic compare_model();
    for (int i = 0; i < NT; i++) begin
      check($sformatf("x%0d", i), dut_x(i), mx[i]);
      check($sformatf("y%0d", i), dut_y(i), my[i]);
    end
    check("score", int'(score), mscore);
    check("level", int'(level), mlevel);
    check("tube_passed", int'(tube_passed), mpulse);
  endtask

  // Drive inputs just after a falling edge, then sample at the next one
  task automatic cycle(input logic ft, input logic ge, input logic c);
    frame_tick = ft;
    game_end   = ge;
    clr        = c;
    @(negedge clk);
    compare_model();
  endtask

  int pulses;
  int y0;
  int ge_r;

  initial begin
    clr        = 1'b1;
    frame_tick = 1'b0;
    game_end   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // reset state
    cycle(0, 0, 0);
    check("rst_x0", dut_x(0), 400);
    check("rst_x1", dut_x(1), 600);
    check("rst_x2", dut_x(2), 800);
    check("rst_y0", dut_y(0), 80);
    check("rst_y1", dut_y(1), 112);
    check("rst_y2", dut_y(2), 144);
    check("rst_score", int'(score), 0);
    check("rst_level", int'(level), 0);

    // single frame: step of 2, gaps unchanged
    cycle(1, 0, 0);
    check("tick_x0", dut_x(0), 398);
    check("tick_x2", dut_x(2), 798);
    check("tick_y1", dut_y(1), 112);
    check("tick_pulse", int'(tube_passed), 0);

    // freeze ignores frame strobes, motion resumes afterwards
    repeat (10) cycle(1, 1, 0);
    check("frozen_x0", dut_x(0), 398);
    cycle(1, 0, 0);
    check("resume_x0", dut_x(0), 396);
    check("resume_x1", dut_x(1), 596);

    // asynchronous clear takes effect before any clock edge
    frame_tick = 1'b0;
    clr        = 1'b1;
    #1;
    check("async_clr_x0", dut_x(0), 400);
    @(negedge clk);
    compare_model();
    cycle(0, 0, 0);

    // 140 frames: tube 0 reaches x=120 and passes the bird once
    pulses = 0;
    for (int k = 0; k < 140; k++) begin
      cycle(1, 0, 0);
      pulses += int'(tube_passed);
    end
    check("pass_x0", dut_x(0), 120);
    check("pass_score", int'(score), 1);
    for (int k = 0; k < 2; k++) begin
      cycle(0, 0, 0);
      pulses += int'(tube_passed);
    end
    check("pass_pulse_count", pulses, 1);

    // tube 0 wraps: 60 frames to x=0, then wrap to 598 with a new gap
    repeat (61) cycle(1, 0, 0);
    check("wrap_x0", dut_x(0), 598);
    y0 = dut_y(0);
    check("wrap_y0_range", int'(y0 >= 80 && y0 <= 335), 1);
    check("wrap_score", int'(score), 1);

    // long run: levels rise to the cap and score saturates
    for (int k = 0; k < 14000; k++) begin
      ge_r = ($urandom_range(0, 19) == 0) ? 1 : 0;
      cycle(($urandom_range(0, 19) != 0), ge_r[0], 0);
    end
    check("sat_score", int'(score), 255);
    check("sat_level", int'(level), 3);
    repeat (100) cycle(1, 0, 0);
    check("sat_score_hold", int'(score), 255);

    // mixed random traffic including occasional mid-run clears
    for (int k = 0; k < 6000; k++) begin
      ge_r = ($urandom_range(0, 9) == 0) ? 1 : 0;
      cycle($urandom_range(0, 1) == 1, ge_r[0], $urandom_range(0, 799) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
